// File: rtl/softmax_norm_seq_pkg.sv
// Shared types and defaults for the softmax normalisation sequencer.
package softmax_pkg;

    localparam int SM_DATA_WIDTH = 8;
    localparam int SM_DEPTH      = 4;
    localparam int SM_CMP_W      = 32;

    typedef enum logic [0:0] {
        LOAD    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    // Signed-max decision: true when cand should replace cur as the running maximum.
    // Callers sign-extend their operands to SM_CMP_W bits.
    function automatic logic is_new_max(input logic signed [SM_CMP_W-1:0] cand,
                                        input logic signed [SM_CMP_W-1:0] cur);
        return cand > cur;
    endfunction

endpackage

// File: rtl/softmax_norm_seq_sub_sub_add.sv
// Three-operand normaliser datapath: result = (-num1) + (-num2) + num3, wrapping.
module sub_sub_add #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] num1,
    input  logic [DATA_WIDTH-1:0] num2,
    input  logic [DATA_WIDTH-1:0] num3,
    output logic [DATA_WIDTH-1:0] result
);

    assign result = (-num1) + (-num2) + num3;

endmodule

// File: rtl/softmax_norm_seq.sv
// Two-phase pseudo-softmax sequencer: buffer a vector and track its max, then
// stream x_i - max - offset through the shared sub_sub_add datapath.
module softmax_norm_seq
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = SM_DATA_WIDTH,
    parameter int DEPTH      = SM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] cfg_offset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t                r_state;
    logic [IDX_W-1:0]      r_wr_idx;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [DATA_WIDTH-1:0] r_max;
    logic [DATA_WIDTH-1:0] r_offset;
    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;

    logic                  w_accept;
    logic                  w_out_load;
    logic                  w_take_max;
    logic [DATA_WIDTH-1:0] w_result;

    assign in_ready   = (r_state == LOAD);
    assign w_accept   = in_valid & in_ready;
    assign w_out_load = (r_state == COMPUTE) & (~r_out_valid | out_ready);
    assign w_take_max = is_new_max(SM_CMP_W'(signed'(in_data)), SM_CMP_W'(signed'(r_max)));

    sub_sub_add #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ssa (
        .num1  (r_max),
        .num2  (r_offset),
        .num3  (r_buf[r_rd_idx]),
        .result(w_result)
    );

    // Buffer holds data only; its contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (!flush && w_accept) begin
            r_buf[r_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_max       <= '0;
            r_offset    <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_state     <= LOAD;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    // A result left over from the previous vector may drain here.
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_accept) begin
                        if (r_wr_idx == '0) begin
                            r_max    <= in_data;
                            r_offset <= cfg_offset;
                        end else if (w_take_max) begin
                            r_max <= in_data;
                        end
                        if (r_wr_idx == LAST_IDX) begin
                            r_wr_idx <= '0;
                            r_state  <= COMPUTE;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (w_out_load) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_rd_idx == LAST_IDX);
                        if (r_rd_idx == LAST_IDX) begin
                            r_rd_idx <= '0;
                            r_state  <= LOAD;
                        end else begin
                            r_rd_idx <= r_rd_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign busy      = (r_state == COMPUTE) | r_out_valid;

endmodule
